// File: rtl/string_pkg.sv
// Shared constants and state encoding for the string ROM and the draw sequencer.
package string_pkg;

  localparam int unsigned STRING_NUM = 13;
  localparam int unsigned MAX_CHAR   = 11;
  localparam int unsigned CHAR_WIDTH = 5;
  localparam logic [4:0]  SPACE_CODE = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/string_draw_sequencer_space_lookahead.sv
// Flags whether any non-space character remains after position idx in a packed string
// (character 0 is the MSB field).
module space_lookahead #(
  parameter int unsigned CW    = 5,
  parameter int unsigned NCHAR = 11,
  parameter int unsigned IW    = 4
) (
  input  logic [CW*NCHAR-1:0] chars,
  input  logic [IW-1:0]       idx,
  output logic                rest_nonspace
);

  import string_pkg::*;

  localparam logic [CW-1:0] SPACE = CW'(SPACE_CODE);

  always_comb begin
    rest_nonspace = 1'b0;
    for (int j = 1; j < NCHAR; j++) begin
      if ((IW'(j) > idx) && (chars[CW*(NCHAR-j)-1 -: CW] != SPACE)) begin
        rest_nonspace = 1'b1;
      end
    end
  end

endmodule

// File: rtl/string_draw_sequencer.sv
// Reads one packed string from string_rom and streams its characters, with pixel
// positions, to the glyph writer over a valid/ready interface.
module string_draw_sequencer #(
  parameter int unsigned STRING_NUM = string_pkg::STRING_NUM,
  parameter int unsigned MAX_CHAR   = string_pkg::MAX_CHAR,
  parameter int unsigned CHAR_WIDTH = string_pkg::CHAR_WIDTH,
  parameter int unsigned CHAR_PIX   = 8,
  parameter int unsigned XW         = 10,
  parameter int unsigned YW         = 10,
  parameter int unsigned ROM_LAT    = 1,
  parameter bit          SKIP_SPACE = 1'b1,
  localparam int unsigned AW        = $clog2(STRING_NUM + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [AW-1:0]                  req_str_id,
  input  logic [XW-1:0]                  req_x,
  input  logic [YW-1:0]                  req_y,
  output logic [AW-1:0]                  rom_addr,
  input  logic [CHAR_WIDTH*MAX_CHAR-1:0] rom_data,
  output logic                           ch_valid,
  input  logic                           ch_ready,
  output logic [CHAR_WIDTH-1:0]          ch_code,
  output logic [XW-1:0]                  ch_x,
  output logic [YW-1:0]                  ch_y,
  output logic                           ch_last,
  output logic                           busy,
  output logic                           done,
  output logic                           bad_id
);

  import string_pkg::*;

  localparam int unsigned IW = (MAX_CHAR > 1) ? $clog2(MAX_CHAR) : 1;
  localparam int unsigned FW = $clog2(ROM_LAT + 1) + 1;
  localparam int unsigned DW = CHAR_WIDTH * MAX_CHAR;
  localparam logic [CHAR_WIDTH-1:0] SPACE = CHAR_WIDTH'(SPACE_CODE);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [DW-1:0]   char_reg, char_n;
  logic [XW-1:0]   x_org, x_org_n;
  logic [YW-1:0]   y_org, y_org_n;
  logic [FW-1:0]   fcnt, fcnt_n;
  logic            bad, bad_n;
  logic [AW-1:0]   rom_addr_n;

  logic                  req_ready_n, busy_n, done_n, bad_id_n;
  logic                  ch_valid_n, ch_last_n;
  logic [CHAR_WIDTH-1:0] code_n;
  logic [XW-1:0]         ch_x_n;
  logic [YW-1:0]         ch_y_n;
  logic                  rest_nonspace;

  // Next-cycle character under the next index; outputs are registered from it.
  always_comb begin
    code_n = '0;
    for (int j = 0; j < MAX_CHAR; j++) begin
      if (idx_n == IW'(j)) code_n = char_n[DW-1-CHAR_WIDTH*j -: CHAR_WIDTH];
    end
  end

  space_lookahead #(
    .CW    (CHAR_WIDTH),
    .NCHAR (MAX_CHAR),
    .IW    (IW)
  ) u_lookahead (
    .chars         (char_n),
    .idx           (idx_n),
    .rest_nonspace (rest_nonspace)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    char_n     = char_reg;
    x_org_n    = x_org;
    y_org_n    = y_org;
    fcnt_n     = fcnt;
    bad_n      = bad;
    rom_addr_n = rom_addr;

    unique case (state)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          x_org_n    = req_x;
          y_org_n    = req_y;
          rom_addr_n = req_str_id;
          fcnt_n     = '0;
          if (req_str_id >= AW'(STRING_NUM)) begin
            bad_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            bad_n   = 1'b0;
            state_n = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (fcnt == FW'(ROM_LAT)) begin
          char_n  = rom_data;
          idx_n   = '0;
          state_n = ST_EMIT;
        end else begin
          fcnt_n = fcnt + FW'(1);
        end
      end
      ST_EMIT: begin
        // ch_valid is low in EMIT only while a skipped space is being consumed.
        if (!ch_valid || ch_ready) begin
          if (idx == IW'(MAX_CHAR - 1)) begin
            state_n = ST_DONE;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    req_ready_n = (state_n == ST_IDLE);
    busy_n      = (state_n != ST_IDLE);
    done_n      = (state_n == ST_DONE);
    bad_id_n    = (state_n == ST_DONE) && bad_n;

    ch_valid_n  = 1'b0;
    ch_last_n   = 1'b0;
    ch_x_n      = '0;
    ch_y_n      = '0;
    if (state_n == ST_EMIT) begin
      ch_valid_n = !(SKIP_SPACE && (code_n == SPACE));
      ch_last_n  = SKIP_SPACE ? !rest_nonspace : (idx_n == IW'(MAX_CHAR - 1));
      ch_x_n     = x_org_n + XW'(idx_n) * XW'(CHAR_PIX);
      ch_y_n     = y_org_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      char_reg  <= '0;
      x_org     <= '0;
      y_org     <= '0;
      fcnt      <= '0;
      bad       <= 1'b0;
      rom_addr  <= '0;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bad_id    <= 1'b0;
      ch_valid  <= 1'b0;
      ch_code   <= '0;
      ch_x      <= '0;
      ch_y      <= '0;
      ch_last   <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      char_reg  <= char_n;
      x_org     <= x_org_n;
      y_org     <= y_org_n;
      fcnt      <= fcnt_n;
      bad       <= bad_n;
      rom_addr  <= rom_addr_n;
      req_ready <= req_ready_n;
      busy      <= busy_n;
      done      <= done_n;
      bad_id    <= bad_id_n;
      ch_valid  <= ch_valid_n;
      ch_code   <= (state_n == ST_EMIT) ? code_n : '0;
      ch_x      <= ch_x_n;
      ch_y      <= ch_y_n;
      ch_last   <= ch_last_n;
    end
  end

endmodule

// File: tb/tb_string_draw_sequencer.sv
// Bench for string_draw_sequencer: one instance skips spaces, one emits them; both are
// checked beat by beat against a string-table model with randomized requests and stalls.
module tb_string_draw_sequencer;

  localparam int unsigned NS  = 13;
  localparam int unsigned MC  = 11;
  localparam int unsigned CW  = 5;
  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 10;
  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = CW * MC;
  localparam int unsigned PIX = 8;

  logic clk = 1'b0;
  logic rst;

  logic          req_valid  [2];
  logic          req_ready  [2];
  logic [AW-1:0] req_str_id [2];
  logic [XW-1:0] req_x      [2];
  logic [YW-1:0] req_y      [2];
  logic [AW-1:0] rom_addr   [2];
  logic [DW-1:0] rom_data   [2];
  logic          ch_valid   [2];
  logic          ch_ready   [2];
  logic [CW-1:0] ch_code    [2];
  logic [XW-1:0] ch_x       [2];
  logic [YW-1:0] ch_y       [2];
  logic          ch_last    [2];
  logic          busy       [2];
  logic          done       [2];
  logic          bad_id     [2];

  int            str_code [16][MC];
  logic [DW-1:0] rom      [16];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  string_draw_sequencer #(.SKIP_SPACE(1'b1)) dut_skip (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_str_id(req_str_id[0]),
    .req_x(req_x[0]), .req_y(req_y[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .ch_valid(ch_valid[0]), .ch_ready(ch_ready[0]), .ch_code(ch_code[0]),
    .ch_x(ch_x[0]), .ch_y(ch_y[0]), .ch_last(ch_last[0]),
    .busy(busy[0]), .done(done[0]), .bad_id(bad_id[0])
  );

  string_draw_sequencer #(.SKIP_SPACE(1'b0)) dut_keep (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_str_id(req_str_id[1]),
    .req_x(req_x[1]), .req_y(req_y[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .ch_valid(ch_valid[1]), .ch_ready(ch_ready[1]), .ch_code(ch_code[1]),
    .ch_x(ch_x[1]), .ch_y(ch_y[1]), .ch_last(ch_last[1]),
    .busy(busy[1]), .done(done[1]), .bad_id(bad_id[1])
  );

  // One-cycle-latency string_rom per instance.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) rom_data[d] <= rom[rom_addr[d]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_skipped(input int id, input int i, input bit skip);
    return skip && (str_code[id][i] == 31);
  endfunction

  function automatic bit exp_last(input int id, input int i, input bit skip);
    if (!skip) return (i == MC - 1);
    for (int j = i + 1; j < MC; j++) if (str_code[id][j] != 31) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int n_beats(input int id, input bit skip);
    int n = 0;
    for (int j = 0; j < MC; j++) if (!is_skipped(id, j, skip)) n++;
    return n;
  endfunction

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic build_rom();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < MC; j++)
        str_code[i][j] = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 26));
    str_code[0]  = '{6, 0, 12, 4, 31, 19, 8, 12, 4, 26, 31};
    str_code[12] = '{8, 13, 18, 19, 17, 20, 2, 19, 8, 14, 13};
    for (int j = 0; j < MC; j++) begin
      str_code[5][j] = 31;
      str_code[7][j] = int'($urandom_range(0, 26));
    end
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < MC; j++)
        rom[i][DW-1-CW*j -: CW] = CW'(str_code[i][j]);
  endtask

  // Issue one request on instance d and check every cycle until it returns to IDLE.
  task automatic run_string(input int d, input int id, input int x, input int y,
                            input int mode, input bit hold);
    bit skip;
    int i, cyc, hs;
    skip = (d == 0);
    check("req_ready_idle", 32'(req_ready[d]), 1);
    req_valid[d]  = 1'b1;
    req_str_id[d] = AW'(id);
    req_x[d]      = XW'(x);
    req_y[d]      = YW'(y);
    ch_ready[d]   = 1'($urandom_range(0, 1));
    step();
    if (!hold) req_valid[d] = 1'b0;
    if (id >= NS) begin
      check("bad_done", 32'(done[d]), 1);
      check("bad_flag", 32'(bad_id[d]), 1);
      check("bad_novalid", 32'(ch_valid[d]), 0);
      check("bad_ready_low", 32'(req_ready[d]), 0);
      step();
      check("bad_ready_back", 32'(req_ready[d]), 1);
      check("bad_done_clear", 32'(done[d]), 0);
      return;
    end
    check("fetch_busy", 32'(busy[d]), 1);
    check("fetch_ready", 32'(req_ready[d]), 0);
    check("fetch_addr", 32'(rom_addr[d]), 32'(id));
    check("fetch_novalid", 32'(ch_valid[d]), 0);
    step();
    check("fetch2_novalid", 32'(ch_valid[d]), 0);
    step();
    i = 0; cyc = 0; hs = 0;
    while (i < MC && cyc < 400) begin
      ch_ready[d] = pick_ready(mode, cyc);
      if (is_skipped(id, i, skip)) begin
        check("space_novalid", 32'(ch_valid[d]), 0);
      end else begin
        check("beat_valid", 32'(ch_valid[d]), 1);
        check("beat_code", 32'(ch_code[d]), 32'(str_code[id][i]));
        check("beat_x", 32'(ch_x[d]), 32'((x + i * PIX) % 1024));
        check("beat_y", 32'(ch_y[d]), 32'(y));
        check("beat_last", 32'(ch_last[d]), 32'(exp_last(id, i, skip)));
      end
      check("emit_nodone", 32'(done[d]), 0);
      if (ch_valid[d] && ch_ready[d]) hs++;
      if (is_skipped(id, i, skip) || ch_ready[d]) i++;
      cyc++;
      step();
    end
    check("emit_count", 32'(i), MC);
    check("handshakes", 32'(hs), 32'(n_beats(id, skip)));
    check("done_pulse", 32'(done[d]), 1);
    check("done_nobad", 32'(bad_id[d]), 0);
    check("done_novalid", 32'(ch_valid[d]), 0);
    check("done_ready", 32'(req_ready[d]), 0);
    check("done_busy", 32'(busy[d]), 1);
    step();
    check("done_clear", 32'(done[d]), 0);
    check("idle_ready", 32'(req_ready[d]), 1);
    check("idle_busy", 32'(busy[d]), 0);
  endtask

  // Reset during the 4th beat of string 7, then confirm a clean restart.
  task automatic run_reset_mid(input int d);
    check("rm_ready", 32'(req_ready[d]), 1);
    req_valid[d]  = 1'b1;
    req_str_id[d] = AW'(7);
    req_x[d]      = XW'(40);
    req_y[d]      = YW'(9);
    ch_ready[d]   = 1'b1;
    step();
    req_valid[d] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("rm_beat3_valid", 32'(ch_valid[d]), 1);
    check("rm_beat3_code", 32'(ch_code[d]), 32'(str_code[7][3]));
    rst = 1'b1;
    step();
    check("rm_valid", 32'(ch_valid[d]), 0);
    check("rm_code", 32'(ch_code[d]), 0);
    check("rm_x", 32'(ch_x[d]), 0);
    check("rm_last", 32'(ch_last[d]), 0);
    check("rm_busy", 32'(busy[d]), 0);
    check("rm_done", 32'(done[d]), 0);
    check("rm_req_ready", 32'(req_ready[d]), 0);
    check("rm_addr", 32'(rom_addr[d]), 0);
    rst = 1'b0;
    step();
    check("rm_after_done", 32'(done[d]), 0);
    check("rm_after_valid", 32'(ch_valid[d]), 0);
    run_string(d, 7, 40, 9, 0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_str_id[d] = '0; req_x[d] = '0; req_y[d] = '0; ch_ready[d] = 1'b0;
    end
    build_rom();
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(req_ready[d]), 0);
      check("rst_busy", 32'(busy[d]), 0);
      check("rst_valid", 32'(ch_valid[d]), 0);
      check("rst_done", 32'(done[d]), 0);
      check("rst_addr", 32'(rom_addr[d]), 0);
    end
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++) check("post_rst_ready", 32'(req_ready[d]), 1);

    run_string(0, 0, 100, 50, 0, 1'b0);
    run_string(0, 0, 100, 50, 1, 1'b0);
    run_string(1, 12, 1000, 3, 0, 1'b0);
    run_string(1, 12, 1000, 3, 1, 1'b0);
    run_string(0, 13, 7, 7, 0, 1'b0);
    run_string(1, 13, 7, 7, 0, 1'b0);
    run_string(0, 5, 20, 20, 2, 1'b0);
    run_string(1, 5, 20, 20, 2, 1'b0);
    run_reset_mid(0);
    run_string(0, 3, 512, 100, 0, 1'b1);
    run_string(0, 8, 1020, 101, 2, 1'b1);
    run_string(0, 14, 0, 0, 0, 1'b1);
    run_string(0, 0, 200, 102, 0, 1'b0);

    for (int n = 0; n < 24; n++) begin
      run_string(int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                 int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
